// File: rtl/branch_pred_ctl.sv
// Branch prediction controller: direct-mapped BTB with 2-bit saturating
// counters. It does a combinational IF lookup and a MEM-stage mispredict check
// that drives flush/redirect. It also keeps resolve statistics and runs a
// sequenced invalidate sweep of the table.
module branch_pred_ctl #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  input  logic        tbl_clr,
  output logic        busy,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;

  // Flattened views of the per-entry registers, used by the read muxes.
  logic [ENTRIES-1:0]             valid_vec;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_arr;
  logic [ENTRIES-1:0][31:0]       target_arr;
  logic [ENTRIES-1:0][1:0]        ctr_arr;

  logic [IDX_W-1:0] if_idx, res_idx;
  logic [TAG_W-1:0] if_tag, res_tag;
  logic             if_hit, res_hit;
  logic             mispredict;
  logic             upd_en;
  logic [15:0]      branch_cnt_reg, mispred_cnt_reg;

  // The two low PC bits are always zero for aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], res_pc[1:0]};

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign res_tag = res_pc[31:IDX_W+2];

  assign busy   = (state_reg == SWEEP);
  assign if_hit = valid_vec[if_idx] && (tag_arr[if_idx] == if_tag);
  assign res_hit = valid_vec[res_idx] && (tag_arr[res_idx] == res_tag);
  // A sweep owns the table, so resolve-side writes are dropped meanwhile.
  assign upd_en = res_valid && !busy;

  // IF lookup: predictions are forced not-taken while the sweep runs.
  always_comb begin
    pred_taken  = if_hit && ctr_arr[if_idx][1] && !busy;
    pred_target = pred_taken ? target_arr[if_idx] : 32'd0;
  end

  // MEM-stage check. A non-branch that was predicted taken is an alias hit.
  always_comb begin
    mispredict = 1'b0;
    if (res_is_branch)
      mispredict = (res_pred_taken != res_taken) ||
                   (res_taken && res_pred_taken && (res_pred_target != res_target));
    else
      mispredict = res_pred_taken;
    flush       = res_valid && mispredict;
    redirect_pc = (res_is_branch && res_taken) ? res_target : (res_pc + 32'd4);
  end

  // One register slice per BTB entry. Sweep clears take priority; they
  // cannot collide with updates because updates are gated by busy.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [31:0]      target_reg;
    logic [1:0]       ctr_reg;

    assign valid_vec[gi]  = valid_reg;
    assign tag_arr[gi]    = tag_reg;
    assign target_arr[gi] = target_reg;
    assign ctr_arr[gi]    = ctr_reg;

    // Entry state: reset, sweep clear, or resolve update.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg  <= 1'b0;
        tag_reg    <= '0;
        target_reg <= 32'd0;
        ctr_reg    <= 2'b01;
      end else if (busy && (idx_reg == MY_IDX)) begin
        valid_reg <= 1'b0;
        ctr_reg   <= 2'b01;
      end else if (upd_en && (res_idx == MY_IDX)) begin
        if (res_is_branch) begin
          if (res_hit) begin
            if (res_taken) begin
              if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'b01;
              target_reg <= res_target;
            end else if (ctr_reg != 2'b00) begin
              ctr_reg <= ctr_reg - 2'b01;
            end
          end else if (res_taken) begin
            valid_reg  <= 1'b1;
            tag_reg    <= res_tag;
            target_reg <= res_target;
            ctr_reg    <= 2'b10;
          end
        end else if (res_pred_taken && res_hit) begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Sweep FSM next state: a tbl_clr mid-sweep restarts from index 0.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (tbl_clr) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end
      SWEEP: begin
        if (tbl_clr) begin
          idx_next = '0;
        end else if (idx_reg == IDX_W'(ENTRIES - 1)) begin
          state_next = IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Saturating statistics; these keep counting during a sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_reg  <= 16'd0;
      mispred_cnt_reg <= 16'd0;
    end else begin
      if (res_valid && res_is_branch && (branch_cnt_reg != 16'hFFFF))
        branch_cnt_reg <= branch_cnt_reg + 16'd1;
      if (flush && (mispred_cnt_reg != 16'hFFFF))
        mispred_cnt_reg <= mispred_cnt_reg + 16'd1;
    end
  end

  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_pred_ctl.sv
// Directed testbench for branch_pred_ctl with hand-computed expectations.
module tb_branch_pred_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        tbl_clr;
  logic        busy;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  int n_err = 0;
  int n_checks = 0;

  branch_pred_ctl #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
    .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .tbl_clr(tbl_clr), .busy(busy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic set_res(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_is_branch   = br;
    res_taken       = tk;
    res_target      = tgt;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
  endtask

  // Advance one full cycle: inputs are driven and checked at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, ".taken"}, 32'(pred_taken), 32'(tk));
    check({tag, ".target"}, pred_target, tgt);
  endtask

  // Pulse tbl_clr, then count busy cycles; optionally restart the sweep
  // during busy cycle restart_at and issue a resolve at busy cycle 10.
  task automatic run_sweep(input int restart_at, output int n);
    n = 0;
    @(negedge clk);
    tbl_clr = 1'b1;
    @(negedge clk);
    tbl_clr = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!busy) break;
      n++;
      tbl_clr = (n == restart_at);
      res_valid = 1'b0;
      if (n == 1 && restart_at == 0) begin
        if_pc = 32'h3C;
        #1;
        check("sweep.pred_gated", 32'(pred_taken), 32'd0);
      end
      if (n == 10 && restart_at == 0) begin
        set_res(32'h0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0);
        #1;
        check("sweep.flush", 32'(flush), 32'd1);
        check("sweep.redirect", redirect_pc, 32'h3000);
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    tbl_clr = 1'b0;
  endtask

  int nb;

  initial begin
    rst = 1'b1; if_pc = 32'h0; tbl_clr = 1'b0;
    res_valid = 1'b0; res_pc = 32'h0; res_is_branch = 1'b0; res_taken = 1'b0;
    res_target = 32'h0; res_pred_taken = 1'b0; res_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    look("rst.look", 32'h40, 1'b0, 32'h0);
    check("rst.branch_cnt", 32'(branch_cnt), 32'd0);
    check("rst.mispred_cnt", 32'(mispred_cnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.flush", 32'(flush), 32'd0);

    // Allocate: taken branch 0x40 -> 0x80; lookup in same cycle sees old contents
    set_res(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check("alloc.flush", 32'(flush), 32'd1);
    check("alloc.redirect", redirect_pc, 32'h80);
    look("alloc.same_cycle", 32'h40, 1'b0, 32'h0);
    step();
    look("alloc.after", 32'h40, 1'b1, 32'h80);

    // Not taken twice: ctr 10->01 (mispredict), 01->00 (correct)
    set_res(32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    check("nt1.flush", 32'(flush), 32'd1);
    check("nt1.redirect", redirect_pc, 32'h44);
    step();
    look("nt1.after", 32'h40, 1'b0, 32'h0);
    set_res(32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 32'h0);
    #1;
    check("nt2.flush", 32'(flush), 32'd0);
    step();
    look("nt2.after", 32'h40, 1'b0, 32'h0);

    // Taken twice: ctr 00->01 then 01->10 with target rewritten to 0x90
    set_res(32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    set_res(32'h40, 1'b1, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    check("tgt.flush", 32'(flush), 32'd1);
    check("tgt.redirect", redirect_pc, 32'h90);
    step();
    look("tgt.after", 32'h40, 1'b1, 32'h90);
    check("tgt.branch_cnt", 32'(branch_cnt), 32'd5);
    check("tgt.mispred_cnt", 32'(mispred_cnt), 32'd4);

    // Alias false hit on a non-branch invalidates the entry
    set_res(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h90);
    #1;
    check("alias.flush", 32'(flush), 32'd1);
    check("alias.redirect", redirect_pc, 32'h44);
    step();
    look("alias.after", 32'h40, 1'b0, 32'h0);
    check("alias.branch_cnt", 32'(branch_cnt), 32'd5);

    // 0x40 and 0x80 share an index; second allocation replaces the first
    set_res(32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    step();
    look("idx.first", 32'h40, 1'b1, 32'h100);
    set_res(32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step();
    look("idx.second", 32'h80, 1'b1, 32'h200);
    look("idx.evicted", 32'h40, 1'b0, 32'h0);
    // Non-branch with mismatching tag must not invalidate
    set_res(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
    look("idx.tag_guard", 32'h80, 1'b1, 32'h200);

    // res_pc + 4 wraps at 32 bits
    res_pc = 32'hFFFF_FFFC; res_is_branch = 1'b0; res_pred_taken = 1'b0;
    #1;
    check("wrap.redirect", redirect_pc, 32'h0);

    // Fill the table
    for (int i = 0; i < 16; i++) begin
      set_res(32'(i * 4), 1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 32'h0);
      step();
    end
    look("fill.e15", 32'h3C, 1'b1, 32'h100F);
    look("fill.e0", 32'h0, 1'b1, 32'h1000);
    check("fill.branch_cnt", 32'(branch_cnt), 32'd23);
    check("fill.mispred_cnt", 32'(mispred_cnt), 32'd24);

    // Sweep: 16 busy cycles, resolves dropped from the table
    run_sweep(0, nb);
    check("sweep.busy_cycles", 32'(nb), 32'd16);
    look("sweep.after_e0", 32'h0, 1'b0, 32'h0);
    look("sweep.after_e15", 32'h3C, 1'b0, 32'h0);
    check("sweep.branch_cnt", 32'(branch_cnt), 32'd24);
    check("sweep.mispred_cnt", 32'(mispred_cnt), 32'd25);

    // Restart during busy cycle 5 -> 21 busy cycles in total
    run_sweep(5, nb);
    check("restart.busy_cycles", 32'(nb), 32'd21);

    // Reset mid-sweep drops busy at once
    @(negedge clk);
    tbl_clr = 1'b1;
    @(negedge clk);
    tbl_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.busy_after", 32'(busy), 32'd0);
    check("abort.branch_cnt", 32'(branch_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 65537 correctly predicted not-taken resolves -> branch_cnt saturates
    set_res(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (65537) @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("sat.branch_cnt", 32'(branch_cnt), 32'hFFFF);
    check("sat.mispred_cnt", 32'(mispred_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctl.md
# branch_pred_ctl

Branch prediction controller for the five-stage pipeline. It holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry and predicts direction and target for the PC in IF. It checks the prediction when the branch resolves in MEM and produces the flush/redirect decision that drives the PC mux. It also keeps prediction statistics and runs a sequenced table-invalidate sweep.

## Interface

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256
- IDX_W, 4, log2(ENTRIES)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- if_pc  in  32  PC being fetched in IF
- pred_taken  out  1  IF prediction: taken
- pred_target  out  32  IF predicted target; valid only when pred_taken=1
- res_valid  in  1  a resolving instruction is in MEM this cycle
- res_pc  in  32  PC of the resolving instruction
- res_is_branch  in  1  the resolving instruction is a conditional branch
- res_taken  in  1  actual direction; ignored if res_is_branch=0
- res_target  in  32  actual branch target
- res_pred_taken  in  1  prediction carried down the pipe with the instruction
- res_pred_target  in  32  predicted target carried down the pipe
- flush  out  1  mispredict; clear IF/ID/EX this cycle
- redirect_pc  out  32  correct next PC; valid when flush=1
- tbl_clr  in  1  start an invalidate sweep (pulse)
- busy  out  1  sweep in progress
- branch_cnt  out  16  resolved branches, saturating
- mispred_cnt  out  16  mispredicts, saturating

## Operation

- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup is combinational. hit = valid & (tag match). pred_taken = hit & ctr[1] & ~busy. pred_target = entry target, or 0 when pred_taken=0.
- Mispredict is computed when res_valid=1, combinationally:
  - Branch: res_pred_taken != res_taken, or (res_taken & res_pred_taken & res_pred_target != res_target).
  - Non-branch with res_pred_taken=1 (alias false hit): mispredict.
- flush = res_valid & mispredict. redirect_pc = res_target if (res_is_branch & res_taken), otherwise res_pc+4 (32-bit wrap).
- Table update on the clock edge when res_valid=1 and busy=0:
  - Branch, hit: ctr saturating +1 if taken, -1 if not (bounded 0..3). Target is rewritten with res_target if taken.
  - Branch, miss, taken: allocate the entry, overwriting any occupant. Set valid=1, tag, target, ctr=2'b10.
  - Branch, miss, not taken: no change.
  - Non-branch with res_pred_taken=1: clear valid at res_pc's index, but only if the tag matches.
- Stats: branch_cnt +1 per res_valid & res_is_branch. mispred_cnt +1 per flush. Both stick at 16'hFFFF.
- Sweep state machine:
  - IDLE: busy=0. tbl_clr moves to SWEEP with idx=0.
  - SWEEP: busy=1. Clears valid[idx] and sets ctr[idx]=2'b01 each cycle, then idx+1. Returns to IDLE after clearing index ENTRIES-1.
  - tbl_clr asserted during SWEEP restarts the sweep at idx=0.
  - While busy=1, predictions are not-taken and table updates are dropped. flush, redirect_pc and the stats counters still operate.

## Timing

- Reset: all valid=0, all ctr=2'b01, targets 0, state IDLE, sweep idx=0, branch_cnt=0, mispred_cnt=0, busy=0. pred_taken=0, pred_target=0. flush and redirect_pc follow the inputs combinationally; flush=0 when res_valid=0.
- Reset asserted mid-sweep aborts the sweep; the reset state above applies.
- Prediction latency is 0 cycles, combinational from if_pc.
- flush and redirect_pc have 0-cycle latency from the res_* inputs.
- A table update is visible to lookup in the cycle after the update edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents.
- tbl_clr in IDLE: busy rises on the next edge and stays high for exactly ENTRIES cycles.
- A sweep clear and an update to the same entry never collide, because updates are dropped while busy.

## Test plan

- Reset, then any if_pc -> pred_taken=0, pred_target=0, both counters 0, busy=0.
- Resolve taken branch at pc=0x40 to target 0x80 (res_pred_taken=0) -> flush=1, redirect_pc=0x80. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice, with the carried prediction matching the predictor each time:
  - First: ctr 10->01, flush=1, redirect_pc=0x44.
  - Second: ctr 01->00, no flush. pred_taken=0 afterwards.
- Taken, predicted taken, but res_pred_target=0x80 vs res_target=0x90 -> flush=1, redirect_pc=0x90. Entry target becomes 0x90; mispred_cnt increments.
- Non-branch at 0x40 with res_pred_taken=1 -> flush=1, redirect_pc=0x44, entry invalidated. Separately, 0x40 and 0x40+4*ENTRIES alias to the same index; allocating the second replaces the first.
- Fill the table, pulse tbl_clr:
  - busy=1 for 16 cycles and all lookups not-taken.
  - A resolve during busy still flushes but leaves the table unchanged.
  - A tbl_clr repeated at cycle 5 extends busy to 21 cycles total.
  - Asserting rst mid-sweep drops busy immediately.
- Drive 65537 branch resolves -> branch_cnt saturates at 0xFFFF.
